// File: rtl/game_progress_tracker.sv
// Per-game progress keeper: lives, 4-digit BCD score, wave and post-hit invulnerability.
// Tracks the game state machine via synchronised v_sync/state and raises game_over_trigger.
module game_progress_tracker #(
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int PTS_PER_ALIEN = 1,
  parameter int MAX_WAVE      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        v_sync,
  input  logic [1:0]  state,
  input  logic        alien_hit,
  input  logic        player_hit,
  input  logic        aliens_cleared,
  input  logic        aliens_landed,
  output logic        game_over_trigger,
  output logic [1:0]  lives,
  output logic [15:0] score_bcd,
  output logic [2:0]  wave,
  output logic        invuln
);

  localparam logic [1:0] START_L  = 2'(START_LIVES);
  localparam logic [7:0] INVULN_T = 8'(INVULN_FRAMES);
  localparam logic [3:0] PTS      = 4'(PTS_PER_ALIEN);
  localparam logic [2:0] MAX_W    = 3'(MAX_WAVE);
  localparam logic [1:0] ST_GAME  = 2'd1;

  typedef enum logic [1:0] {IDLE, PLAY, DYING, OVER} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic        vs_s1_q, vs_s2_q, vs_prev_q;
  logic [1:0]  st_s1_q, st_s2_q, st_prev_q;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [2:0]  wave_q, wave_d;
  logic [7:0]  timer_q, timer_d;
  logic        gover_q, gover_d;

  logic frame_tick, game_start, in_game, active;

  // Adds pts to the units digit with decimal carry ripple; a carry out of thousands pins 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] s, input logic [3:0] pts);
    logic [4:0]  sum;
    logic [3:0]  c;
    logic [15:0] r;
    r = s;
    c = pts;
    for (int i = 0; i < 4; i++) begin
      sum = {1'b0, s[4*i +: 4]} + {1'b0, c};
      if (sum > 5'd9) begin
        r[4*i +: 4] = 4'(sum - 5'd10);
        c = 4'd1;
      end else begin
        r[4*i +: 4] = sum[3:0];
        c = 4'd0;
      end
    end
    if (c != 4'd0) r = 16'h9999;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      vs_prev_q <= 1'b0;
      st_s1_q   <= 2'd0;
      st_s2_q   <= 2'd0;
      st_prev_q <= 2'd0;
    end else begin
      vs_s1_q   <= v_sync;
      vs_s2_q   <= vs_s1_q;
      vs_prev_q <= vs_s2_q;
      st_s1_q   <= state;
      st_s2_q   <= st_s1_q;
      st_prev_q <= st_s2_q;
    end
  end

  assign frame_tick = vs_s2_q & ~vs_prev_q;
  assign in_game    = (st_s2_q == ST_GAME);
  assign game_start = in_game && (st_prev_q != ST_GAME);
  assign active     = ((fsm_q == PLAY) || (fsm_q == DYING)) && in_game;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      lives_q <= 2'd0;
      score_q <= 16'h0000;
      wave_q  <= 3'd0;
      timer_q <= 8'd0;
      gover_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lives_q <= lives_d;
      score_q <= score_d;
      wave_q  <= wave_d;
      timer_q <= timer_d;
      gover_q <= gover_d;
    end
  end

  // Leaving GAME externally overrides everything; aliens_landed beats player_hit.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:  if (game_start) fsm_d = PLAY;
      PLAY: begin
        if (!in_game)          fsm_d = IDLE;
        else if (aliens_landed) fsm_d = OVER;
        else if (player_hit)    fsm_d = (lives_q > 2'd1) ? DYING : OVER;
      end
      DYING: begin
        if (!in_game)                             fsm_d = IDLE;
        else if (aliens_landed)                   fsm_d = OVER;
        else if (frame_tick && timer_q == 8'd1)   fsm_d = PLAY;
      end
      OVER:  if (!in_game) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    lives_d = lives_q;
    score_d = score_q;
    wave_d  = wave_q;
    timer_d = timer_q;
    gover_d = (fsm_d == OVER);
    if (fsm_q == IDLE && game_start) begin
      lives_d = START_L;
      score_d = 16'h0000;
      wave_d  = 3'd0;
      timer_d = 8'd0;
    end else if (active) begin
      if (alien_hit)                          score_d = bcd_add_sat(score_q, PTS);
      if (aliens_cleared && wave_q < MAX_W)   wave_d  = wave_q + 3'd1;
      if (aliens_landed) begin
        lives_d = 2'd0;
      end else if (fsm_q == PLAY && player_hit) begin
        if (lives_q > 2'd1) begin
          lives_d = lives_q - 2'd1;
          timer_d = INVULN_T;
        end else begin
          lives_d = 2'd0;
        end
      end else if (fsm_q == DYING && frame_tick && timer_q != 8'd0) begin
        timer_d = timer_q - 8'd1;
      end
    end
  end

  assign game_over_trigger = gover_q;
  assign lives             = lives_q;
  assign score_bcd         = score_q;
  assign wave              = wave_q;
  assign invuln            = (fsm_q == DYING);

endmodule
